// File: rtl/ps2_lane_key_tracker_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 lane key tracker.
//   PS2_BREAK / PS2_EXT  : prefix bytes for break (F0) and extended (E0) sequences.
//   LANEn_DEFAULT        : default scancodes for the four lane keys A/S/D/F.
//   ps2_state_e          : prefix decoder state.
//   ps2_is_ignored()     : keyboard status/ack bytes that never count as keys.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] LANE0_DEFAULT = 8'h1C;
  localparam logic [7:0] LANE1_DEFAULT = 8'h1B;
  localparam logic [7:0] LANE2_DEFAULT = 8'h23;
  localparam logic [7:0] LANE3_DEFAULT = 8'h2B;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

  // BAT-ok, ack, resend, echo, and the two error/overrun codes.
  function automatic logic ps2_is_ignored(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
           (code == 8'hEE) || (code == 8'h00) || (code == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_lane_key_tracker_if.sv
// ps2_lane_key_tracker_if: byte input from the PS/2 receiver and the decoded
// key outputs toward the game datapath.
//   master : drives rx_data/rx_valid, observes the key outputs.
//   slave  : the tracker; consumes bytes, drives key_code, key_extended,
//            key_press, key_release, lane_held, seq_error.
interface ps2_lane_key_tracker_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_press;
  logic       key_release;
  logic [3:0] lane_held;
  logic       seq_error;

  modport master (
    output rx_data, rx_valid,
    input  key_code, key_extended, key_press, key_release, lane_held, seq_error
  );

  modport slave (
    input  rx_data, rx_valid,
    output key_code, key_extended, key_press, key_release, lane_held, seq_error
  );
endinterface

// File: rtl/ps2_lane_key_tracker_timeout.sv
// ps2_prefix_timeout: watchdog for a pending prefix sequence.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : force the count to 0 (byte accepted, or decoder idle)
//   en_i       : count this cycle
//   expire_o   : high while enabled and the count sits at TIMEOUT_CYCLES-1
module ps2_prefix_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = expire_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ps2_lane_key_tracker.sv
// ps2_lane_key_tracker: decodes PS/2 make / F0 break / E0 extended sequences
// and tracks which lane keys (A/S/D/F) are held.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : ps2_lane_key_tracker_if.slave (rx_data/rx_valid in;
//                key_code, key_extended, key_press, key_release,
//                lane_held, seq_error out, all registered)
// Optional: define PS2_TYPEMATIC_FILTER_EN to swallow repeated makes of a
// lane key that is already held.
//
// state   | meaning
// IDLE    | no prefix pending; plain bytes are makes
// BRK     | F0 seen; next byte is released
// EXT     | E0 seen; next byte is an extended make
// EXT_BRK | E0 F0 seen; next byte is an extended release
module ps2_lane_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0]  LANE0_CODE     = LANE0_DEFAULT,
  parameter logic [7:0]  LANE1_CODE     = LANE1_DEFAULT,
  parameter logic [7:0]  LANE2_CODE     = LANE2_DEFAULT,
  parameter logic [7:0]  LANE3_CODE     = LANE3_DEFAULT
) (
  input logic                   clk,
  input logic                   reset,
  ps2_lane_key_tracker_if.slave bus
);

  ps2_state_e state_q, state_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic [3:0] lane_q, lane_d;
  logic       err_q, err_d;

  logic [3:0] lane_hit;
  logic [3:0] lane_after;
  logic       expire;

  assign lane_hit = {bus.rx_data == LANE3_CODE, bus.rx_data == LANE2_CODE,
                     bus.rx_data == LANE1_CODE, bus.rx_data == LANE0_CODE};

  ps2_prefix_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (bus.rx_valid || (state_q == IDLE)),
    .en_i    (state_q != IDLE),
    .expire_o(expire)
  );

  always_comb begin
    state_d    = state_q;
    key_code_d = key_code_q;
    key_ext_d  = key_ext_q;
    lane_d     = lane_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    err_d      = 1'b0;
    lane_after = lane_q;

    if (bus.rx_valid) begin
      // A byte on the expiry cycle is still consumed in the prefix state.
      unique case (state_q)
        IDLE: begin
          if (bus.rx_data == PS2_BREAK) begin
            state_d = BRK;
          end else if (bus.rx_data == PS2_EXT) begin
            state_d = EXT;
          end else if (!ps2_is_ignored(bus.rx_data)) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if ((lane_hit & lane_q) == 4'b0000) begin
              key_code_d = bus.rx_data;
              key_ext_d  = 1'b0;
              press_d    = 1'b1;
              lane_d     = lane_q | lane_hit;
            end
`else
            key_code_d = bus.rx_data;
            key_ext_d  = 1'b0;
            press_d    = 1'b1;
            lane_d     = lane_q | lane_hit;
`endif
          end
        end
        EXT: begin
          if (bus.rx_data == PS2_BREAK) begin
            state_d = EXT_BRK;
          end else if (bus.rx_data == PS2_EXT) begin
            err_d = 1'b1;
          end else begin
            key_code_d = bus.rx_data;
            key_ext_d  = 1'b1;
            press_d    = 1'b1;
            state_d    = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          state_d = IDLE;
          if ((bus.rx_data == PS2_BREAK) || (bus.rx_data == PS2_EXT)) begin
            err_d = 1'b1;
          end else begin
            release_d = 1'b1;
            // Extended keys share codes with nothing in the lane set, so
            // an E0 F0 break must not disturb lane bits.
            if (state_q == BRK) lane_after = lane_q & ~lane_hit;
            lane_d = lane_after;
            if ((bus.rx_data == key_code_q) && (key_ext_q == (state_q == EXT_BRK))) begin
              key_ext_d = 1'b0;
              if      (lane_after[0]) key_code_d = LANE0_CODE;
              else if (lane_after[1]) key_code_d = LANE1_CODE;
              else if (lane_after[2]) key_code_d = LANE2_CODE;
              else if (lane_after[3]) key_code_d = LANE3_CODE;
              else                    key_code_d = 8'h00;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (expire) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      key_code_q <= 8'h00;
      key_ext_q  <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      lane_q     <= 4'b0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_code_q <= key_code_d;
      key_ext_q  <= key_ext_d;
      press_q    <= press_d;
      release_q  <= release_d;
      lane_q     <= lane_d;
      err_q      <= err_d;
    end
  end

  assign bus.key_code     = key_code_q;
  assign bus.key_extended = key_ext_q;
  assign bus.key_press    = press_q;
  assign bus.key_release  = release_q;
  assign bus.lane_held    = lane_q;
  assign bus.seq_error    = err_q;

endmodule

// File: tb/tb_ps2_lane_key_tracker.sv
// Testbench for ps2_lane_key_tracker: directed byte vectors with hand-computed
// expected outputs, plus sequences for timeout, expiry coincidence and reset.
// Honors PS2_TYPEMATIC_FILTER_EN for the repeat-make expectations.
module tb_ps2_lane_key_tracker;

  localparam int T = 16;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ps2_lane_key_tracker_if bus ();

  ps2_lane_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] kc;
    logic       ext;
    logic       pr;
    logic       rl;
    logic [3:0] ln;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic [7:0] kc, logic ext,
                              logic pr, logic rl, logic [3:0] ln, logic er);
    vec_t r;
    r.v = v; r.d = d; r.kc = kc; r.ext = ext; r.pr = pr; r.rl = rl; r.ln = ln; r.er = er;
    return r;
  endfunction

  function automatic logic [15:0] outs();
    return {bus.key_code, bus.key_extended, bus.key_press, bus.key_release,
            bus.lane_held, bus.seq_error};
  endfunction

  function automatic logic [15:0] pack(logic [7:0] kc, logic ext, logic pr, logic rl,
                                       logic [3:0] ln, logic er);
    return {kc, ext, pr, rl, ln, er};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outs()), 32'(16'h0000));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_err;
    int err_cnt;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    //          v  data   kc     ext pr rl lane     er
    vecs.push_back(mk(1, 8'h1C, 8'h1C, 0, 1, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 8'hF0, 8'h1C, 0, 0, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 8'h1C, 8'h00, 0, 0, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 8'h1C, 8'h1C, 0, 1, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 8'h2B, 8'h2B, 0, 1, 0, 4'b1001, 0));
    vecs.push_back(mk(1, 8'hF0, 8'h2B, 0, 0, 0, 4'b1001, 0));
    vecs.push_back(mk(1, 8'h2B, 8'h1C, 0, 0, 1, 4'b0001, 0));
    vecs.push_back(mk(1, 8'hF0, 8'h1C, 0, 0, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 8'h1C, 8'h00, 0, 0, 1, 4'b0000, 0));
    vecs.push_back(mk(1, 8'hE0, 8'h00, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 8'h75, 8'h75, 1, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 8'hE0, 8'h75, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 8'hF0, 8'h75, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 8'h75, 8'h00, 0, 0, 1, 4'b0000, 0));
    vecs.push_back(mk(1, 8'hE0, 8'h00, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 8'hE0, 8'h00, 0, 0, 0, 4'b0000, 1));
    vecs.push_back(mk(1, 8'h12, 8'h12, 1, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 8'hF0, 8'h12, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 8'hE0, 8'h12, 1, 0, 0, 4'b0000, 1));
    vecs.push_back(mk(1, 8'hAA, 8'h12, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 8'h23, 8'h23, 0, 1, 0, 4'b0100, 0));
    vecs.push_back(mk(1, 8'hF0, 8'h23, 0, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(1, 8'h1B, 8'h23, 0, 0, 1, 4'b0100, 0));
    vecs.push_back(mk(1, 8'hE0, 8'h23, 0, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(1, 8'hF0, 8'h23, 0, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(1, 8'h23, 8'h23, 0, 0, 1, 4'b0100, 0));
    vecs.push_back(mk(1, 8'h1C, 8'h1C, 0, 1, 0, 4'b0101, 0));
    vecs.push_back(mk(1, 8'h1C, 8'h1C, 0, !FILT, 0, 4'b0101, 0));
    vecs.push_back(mk(1, 8'h1C, 8'h1C, 0, !FILT, 0, 4'b0101, 0));
    vecs.push_back(mk(1, 8'h12, 8'h12, 0, 1, 0, 4'b0101, 0));
    vecs.push_back(mk(1, 8'h12, 8'h12, 0, 1, 0, 4'b0101, 0));
    vecs.push_back(mk(0, 8'hF0, 8'h12, 0, 0, 0, 4'b0101, 0));
    vecs.push_back(mk(1, 8'h00, 8'h12, 0, 0, 0, 4'b0101, 0));
    vecs.push_back(mk(1, 8'h2B, 8'h2B, 0, 1, 0, 4'b1101, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(outs()), 32'(16'h0000));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_byte%h", i, vecs[i].d), 32'(outs()),
          32'(pack(vecs[i].kc, vecs[i].ext, vecs[i].pr, vecs[i].rl, vecs[i].ln, vecs[i].er)));
    end

    // Prefix timeout with no further bytes.
    do_reset();
    step(1'b1, 8'hF0);
    first_err = 0;
    err_cnt   = 0;
    for (int i = 1; i <= T + 3; i++) begin
      step(1'b0, 8'h00);
      if (bus.seq_error) begin
        err_cnt++;
        if (first_err == 0) first_err = i;
      end
    end
    chk("timeout_cycle", 32'(first_err), 32'(T));
    chk("timeout_pulses", 32'(err_cnt), 32'd1);
    step(1'b1, 8'h23);
    chk("make_after_timeout", 32'(outs()), 32'(pack(8'h23, 0, 1, 0, 4'b0100, 0)));

    // Byte arriving on the expiry cycle is still a break.
    step(1'b1, 8'hF0);
    err_cnt = 0;
    for (int i = 1; i <= T - 1; i++) begin
      step(1'b0, 8'h00);
      if (bus.seq_error) err_cnt++;
    end
    chk("pre_expiry_quiet", 32'(err_cnt), 32'd0);
    step(1'b1, 8'h23);
    chk("break_on_expiry", 32'(outs()), 32'(pack(8'h00, 0, 0, 1, 4'b0000, 0)));
    step(1'b0, 8'h00);
    chk("after_expiry_break", 32'(outs()), 32'(16'h0000));

    // Reset between F0 and the key discards the pending break.
    step(1'b1, 8'h1C);
    chk("make_before_reset", 32'(outs()), 32'(pack(8'h1C, 0, 1, 0, 4'b0001, 0)));
    step(1'b1, 8'hF0);
    do_reset();
    step(1'b1, 8'h1C);
    chk("make_after_reset", 32'(outs()), 32'(pack(8'h1C, 0, 1, 0, 4'b0001, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_lane_key_tracker.md
Name: ps2_lane_key_tracker

Overview:
- Sits between the PS/2 byte receiver and the game datapath.
- Consumes raw scancode bytes and decodes the make, break (F0) and extended (E0) prefix sequences.
- Tracks which of the four lane keys (A/S/D/F) are held.
- Presents a stable held-key byte on key_code, which feeds the datapath's datareceived input, plus one-cycle press/release strobes for scoring and debug.

Parameters:
- TIMEOUT_CYCLES, 2500000: cycles a prefix state may wait for its next byte before aborting to IDLE (50 ms at 50 MHz).
- LANE0_CODE, 8'h1C: scancode for lane 0 (A).
- LANE1_CODE, 8'h1B: scancode for lane 1 (S).
- LANE2_CODE, 8'h23: scancode for lane 2 (D).
- LANE3_CODE, 8'h2B: scancode for lane 3 (F).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the PS/2 receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid while high.
- key_code  out  8  currently held key code; 8'h00 when no key is held.
- key_extended  out  1  key_code came from an E0-prefixed make.
- key_press  out  1  one-cycle pulse on an accepted make.
- key_release  out  1  one-cycle pulse on an accepted break.
- lane_held  out  4  bit n set while lane n key is held.
- seq_error  out  1  one-cycle pulse on prefix timeout or an illegal prefix sequence.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-sequence discards any partial prefix.
- Latency: every output updates on the clk edge that samples rx_valid=1 (registered; visible the following cycle). Bytes with rx_valid=0 are ignored.
- States: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- IDLE transitions:
  - F0 -> BRK.
  - E0 -> EXT.
  - AA, FA, FE, EE, 00, FF: ignored, stay in IDLE.
  - Any other byte is a make: key_code<=byte, key_extended<=0, key_press pulse. If the byte is a lane code, set its lane_held bit.
- EXT transitions:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT, seq_error pulse.
  - Other byte: make with key_extended<=1, key_press pulse, lane_held unchanged, -> IDLE.
- BRK and EXT_BRK transitions:
  - F0 or E0: seq_error pulse, -> IDLE, no release.
  - Other byte: break, key_release pulse, -> IDLE.
    - BRK of a lane code clears that lane bit. EXT_BRK never touches lane bits.
- key_code update on a break:
  - If the released code equals key_code (and key_extended matches the break type), key_code becomes the code of the lowest-index lane still held, with key_extended=0. If no lane is held, key_code=8'h00.
  - Otherwise key_code is unchanged.
- Break of a key not held: key_release still pulses, no other change.
- Timeout:
  - The counter runs only in non-IDLE states and clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES-1: -> IDLE, seq_error pulse.
  - If rx_valid coincides with the expiry cycle, the byte wins and is processed in the prefix state. No seq_error.
- key_press, key_release and seq_error are never high for more than one cycle per byte. Press and release are mutually exclusive.
- Widths: counter sized $clog2(TIMEOUT_CYCLES). No arithmetic on codes.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined: a make for a lane whose lane_held bit is already set is swallowed. No key_press, key_code unchanged. Non-lane repeats still pulse.
- Undefined: every make, including typematic repeats, updates key_code and pulses key_press.

Decomposition:
- Package ps2_pkg holds:
  - localparams PS2_BREAK=8'hF0, PS2_EXT=8'hE0.
  - The ignored-code list: AA, FA, FE, EE, 00, FF.
  - Default lane codes.
  - The state typedef (2-bit enum: IDLE, BRK, EXT, EXT_BRK).
- One sub-module, ps2_prefix_timeout: counter with clear/enable inputs and an expire output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset, then 1C: key_code=1C, lane_held=0001, one key_press pulse. Then F0 1C: key_code=00, lane_held=0000, one key_release pulse.
- 1C, 2B, F0 2B: lane_held 0001 -> 1001 -> 0001; key_code 1C -> 2B -> 1C.
- E0 75 then E0 F0 75: key_code=75 with key_extended=1, lane_held unchanged; the break returns key_code to 00.
- F0 followed by 2500000 idle cycles: seq_error pulse exactly at cycle TIMEOUT_CYCLES-1. A subsequent 23 is treated as a make (lane_held=0100). Variant: 23 arriving on the expiry cycle is processed as a break, with no seq_error.
- 1C 1C 1C: macro undefined gives 3 key_press pulses; macro defined gives 1.
- Reset asserted between F0 and 1C after a 1C make: all outputs 0. The following 1C is a make, not a break.
